psum_accum_col: RTL and testbench

Column output stage of the 8x8 weight-stationary systolic array. One instance sits below each array column and consumes the 16-bit signed partial sum leaving the bottom MAC unit. It accumulates that partial sum across several input-channel passes into a local buffer, then drains the buffer as requantized 8-bit activations over a valid/ready handshake to the feature-map writer.

---
 rtl/psum_pkg.sv | 19 +
 rtl/psum_accum_col_if.sv | 33 +++
 rtl/psum_requant.sv | 40 ++++
 rtl/psum_accum_col.sv | 151 +++++++++++++++
 tb/tb_psum_accum_col.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/psum_pkg.sv
// Shared types and default sizing for the systolic-array column output stage.
package psum_pkg;

   localparam int WD    = 8;
   localparam int ACC_W = 24;
   localparam int DEPTH = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
   localparam int ACC_MIN = -(1 << (ACC_W - 1));
   localparam int OUT_MAX = (1 << (WD - 1)) - 1;
   localparam int OUT_MIN = -(1 << (WD - 1));

endpackage

// File: rtl/psum_accum_col_if.sv
// Config, psum input and output handshake bundle of one column output stage.
interface psum_accum_col_if #(
   parameter int WD    = psum_pkg::WD,
   parameter int DEPTH = psum_pkg::DEPTH
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic                   cfg_start;
   logic [3:0]             cfg_npass;
   logic [LW-1:0]          cfg_len;
   logic [4:0]             cfg_shift;
   logic                   psum_valid;
   logic signed [2*WD-1:0] psum_in;
   logic                   out_valid;
   logic                   out_ready;
   logic signed [WD-1:0]   out_data;
   logic                   busy;
   logic                   done;
   logic                   ovf;

   modport master (
      output cfg_start, cfg_npass, cfg_len, cfg_shift,
      output psum_valid, psum_in, out_ready,
      input  out_valid, out_data, busy, done, ovf
   );

   modport slave (
      input  cfg_start, cfg_npass, cfg_len, cfg_shift,
      input  psum_valid, psum_in, out_ready,
      output out_valid, out_data, busy, done, ovf
   );

endinterface

// File: rtl/psum_requant.sv
// Rounding right shift and saturation of an accumulator to WD bits.
// Define RELU_EN to clamp negative results to zero before saturation.
module psum_requant #(
   parameter int WD    = psum_pkg::WD,
   parameter int ACC_W = psum_pkg::ACC_W
) (
   input  logic signed [ACC_W-1:0] i_acc,
   input  logic [4:0]              i_shift,
   output logic signed [WD-1:0]    o_q
);

   localparam logic signed [ACC_W:0] QMAX =
      {{(ACC_W+2-WD){1'b0}}, {(WD-1){1'b1}}};
   localparam logic signed [ACC_W:0] QMIN =
      {{(ACC_W+2-WD){1'b1}}, {(WD-1){1'b0}}};

   // one extra bit keeps the rounding add from overflowing
   logic signed [ACC_W:0] w_ext;
   logic signed [ACC_W:0] w_half;
   logic signed [ACC_W:0] w_r;

   always_comb begin
      w_ext  = (ACC_W+1)'(i_acc);
      w_half = '0;
      if (i_shift != 5'd0)
         w_half = (ACC_W+1)'(1) << (i_shift - 5'd1);
      w_r = (w_ext + w_half) >>> i_shift;
`ifdef RELU_EN
      if (w_r[ACC_W])
         w_r = '0;
`endif
      if (w_r > QMAX)
         o_q = QMAX[WD-1:0];
      else if (w_r < QMIN)
         o_q = QMIN[WD-1:0];
      else
         o_q = w_r[WD-1:0];
   end

endmodule

// File: rtl/psum_accum_col.sv
// Column output stage: multi-pass psum accumulation, then requantized drain.
// Define RELU_EN to drain only non-negative activations.
module psum_accum_col #(
   parameter int WD    = psum_pkg::WD,
   parameter int ACC_W = psum_pkg::ACC_W,
   parameter int DEPTH = psum_pkg::DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   psum_accum_col_if.slave  bus
);
   import psum_pkg::*;

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   state_t                 r_state;
   logic [PW-1:0]          r_ptr;
   logic [PW-1:0]          r_lenm1;
   logic [3:0]             r_pass;
   logic [3:0]             r_lastp;
   logic [4:0]             r_shift;
   logic                   r_ovf;
   logic                   r_ov;
   logic                   r_done;
   logic                   r_rdone;
   logic signed [WD-1:0]   r_od;
   logic signed [ACC_W-1:0] r_acc [DEPTH];

   logic signed [ACC_W-1:0] w_ext;
   logic signed [ACC_W-1:0] w_rd;
   logic signed [ACC_W-1:0] w_wdata;
   logic signed [ACC_W:0]   w_sum;
   logic                    w_sat;
   logic                    w_wr;
   logic                    w_last;
   logic                    w_fire;
   logic                    w_load;
   logic [PW-1:0]           w_lenm1;
   logic [3:0]              w_lastp;
   logic signed [WD-1:0]    w_q;

   assign w_ext  = ACC_W'(bus.psum_in);
   assign w_rd   = r_acc[r_ptr];
   assign w_sum  = (ACC_W+1)'(w_rd) + (ACC_W+1)'(w_ext);
   assign w_wr   = (r_state == ACCUM) && bus.psum_valid;
   assign w_last = (r_ptr == r_lenm1);
   assign w_fire = r_ov && bus.out_ready;
   assign w_load = (r_state == DRAIN) && (!r_ov || bus.out_ready)
                   && !r_rdone;

   assign w_lenm1 = (bus.cfg_len == '0) ? '1
                    : PW'(bus.cfg_len - LW'(1));
   assign w_lastp = (bus.cfg_npass == 4'd0) ? 4'd0
                    : bus.cfg_npass - 4'd1;

   always_comb begin
      w_sat   = 1'b0;
      w_wdata = w_ext;
      if (r_pass != 4'd0) begin
         w_wdata = w_sum[ACC_W-1:0];
         if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
            w_sat   = 1'b1;
            w_wdata = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
         end
      end
   end

   psum_requant #(.WD(WD), .ACC_W(ACC_W)) u_rq (
      .i_acc   (w_rd),
      .i_shift (r_shift),
      .o_q     (w_q)
   );

   // buffer is never cleared: pass 0 overwrites every entry
   always_ff @(posedge clk) begin
      if (rst_n && w_wr)
         r_acc[r_ptr] <= w_wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_lenm1 <= '0;
         r_pass  <= '0;
         r_lastp <= '0;
         r_shift <= '0;
         r_ovf   <= 1'b0;
         r_ov    <= 1'b0;
         r_od    <= '0;
         r_done  <= 1'b0;
         r_rdone <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (bus.cfg_start) begin
                  r_lenm1 <= w_lenm1;
                  r_lastp <= w_lastp;
                  r_shift <= bus.cfg_shift;
                  r_ptr   <= '0;
                  r_pass  <= '0;
                  r_ovf   <= 1'b0;
                  r_rdone <= 1'b0;
                  r_state <= ACCUM;
               end
            end
            ACCUM: begin
               if (bus.psum_valid) begin
                  if (w_sat)
                     r_ovf <= 1'b1;
                  if (w_last) begin
                     r_ptr  <= '0;
                     r_pass <= r_pass + 4'd1;
                     if (r_pass == r_lastp)
                        r_state <= DRAIN;
                  end else begin
                     r_ptr <= r_ptr + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (w_load) begin
                  r_ov <= 1'b1;
                  r_od <= w_q;
                  if (w_last)
                     r_rdone <= 1'b1;
                  else
                     r_ptr <= r_ptr + 1'b1;
               end else if (w_fire) begin
                  r_ov <= 1'b0;
                  if (r_rdone) begin
                     r_done  <= 1'b1;
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.out_valid = r_ov;
   assign bus.out_data  = r_od;
   assign bus.busy      = (r_state != IDLE);
   assign bus.done      = r_done;
   assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_psum_accum_col.sv
// Bench for psum_accum_col: ACC_W=24 and ACC_W=16 instances share stimulus.
module tb_psum_accum_col;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   psum_accum_col_if #(.WD(8), .DEPTH(16)) bus ();
   psum_accum_col_if #(.WD(8), .DEPTH(16)) bus16 ();

   psum_accum_col #(.WD(8), .ACC_W(24), .DEPTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   psum_accum_col #(.WD(8), .ACC_W(16), .DEPTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .bus(bus16)
   );

   assign bus16.cfg_start  = bus.cfg_start;
   assign bus16.cfg_npass  = bus.cfg_npass;
   assign bus16.cfg_len    = bus.cfg_len;
   assign bus16.cfg_shift  = bus.cfg_shift;
   assign bus16.psum_valid = bus.psum_valid;
   assign bus16.psum_in    = bus.psum_in;
   assign bus16.out_ready  = bus.out_ready;

   int n_tests = 0;
   int n_fail  = 0;
   longint ps [16][16];
   longint exp24 [16];
   longint exp16 [16];
   bit ov24, ov16;
   longint last24, last16;
   logic [6:0] pat = 7'b1101001;

   task automatic check(input string tag,
                        input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint rq(longint a, int sh);
      longint r;
      r = a;
      if (sh > 0)
         r = (a + (64'sd1 <<< (sh - 1))) >>> sh;
`ifdef RELU_EN
      if (r < 0) r = 0;
`endif
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      return r;
   endfunction

   function automatic void model(int np, int ln, int sh);
      longint a, mx, mn, e;
      bit ov;
      int aw;
      for (int w = 0; w < 2; w++) begin
         aw = (w == 0) ? 24 : 16;
         mx = (64'sd1 <<< (aw - 1)) - 1;
         mn = -mx - 1;
         ov = 0;
         for (int i = 0; i < ln; i++) begin
            a = ps[0][i];
            for (int p = 1; p < np; p++) begin
               a = a + ps[p][i];
               if (a > mx) begin a = mx; ov = 1; end
               else if (a < mn) begin a = mn; ov = 1; end
            end
            e = rq(a, sh);
            if (w == 0) exp24[i] = e;
            else        exp16[i] = e;
         end
         if (w == 0) ov24 = ov;
         else        ov16 = ov;
      end
   endfunction

   task automatic run_tile(input int np, input int ln, input int sh,
                           input int rmode, input bit rnd,
                           input string nm, input int rst_at);
      int enp, eln, k, cyc, pi;
      bit stall, rdy;
      logic signed [7:0] pd, pd16;
      enp = (np == 0) ? 1 : np;
      eln = (ln == 0) ? 16 : ln;
      if (rnd)
         for (int p = 0; p < enp; p++)
            for (int i = 0; i < eln; i++)
               case ($urandom_range(0, 7))
                  0:       ps[p][i] = 32767;
                  1:       ps[p][i] = -32768;
                  default: ps[p][i] = longint'($signed(16'($urandom)));
               endcase
      model(enp, eln, sh);

      bus.cfg_start  = 1'b1;
      bus.cfg_npass  = np[3:0];
      bus.cfg_len    = ln[4:0];
      bus.cfg_shift  = sh[4:0];
      bus.psum_valid = 1'b1;
      bus.psum_in    = 16'sh7fff;
      @(negedge clk);
      bus.cfg_start  = 1'b0;
      bus.psum_valid = 1'b0;
      check({nm, "_busy"}, bus.busy, 1);

      for (int p = 0; p < enp; p++)
         for (int i = 0; i < eln; i++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
               bus.psum_valid = 1'b0;
               bus.psum_in    = 16'($urandom);
               @(negedge clk);
            end
            bus.psum_valid = 1'b1;
            bus.psum_in    = 16'(ps[p][i]);
            if (p == 0 && i == 0) begin
               bus.cfg_start = 1'b1;
               bus.cfg_npass = 4'd2;
               bus.cfg_len   = 5'd1;
               bus.cfg_shift = 5'd3;
            end
            @(negedge clk);
            bus.cfg_start = 1'b0;
         end
      bus.psum_valid = 1'b0;

      k = 0; cyc = 0; stall = 0; pi = 0;
      pd = '0; pd16 = '0;
      while (k < eln && cyc < 40 * eln + 40) begin
         if (rst_at >= 0 && k == rst_at && bus.out_valid) begin
            rst_n = 1'b0;
            @(negedge clk);
            check({nm, "_rv"},  bus.out_valid, 0);
            check({nm, "_rd"},  bus.out_data, 0);
            check({nm, "_rb"},  bus.busy, 0);
            check({nm, "_rdn"}, bus.done, 0);
            check({nm, "_ro"},  bus.ovf, 0);
            check({nm, "_rv16"},  bus16.out_valid, 0);
            check({nm, "_rd16"},  bus16.out_data, 0);
            check({nm, "_rb16"},  bus16.busy, 0);
            check({nm, "_rdn16"}, bus16.done, 0);
            rst_n = 1'b1;
            bus.out_ready = 1'b1;
            bus.psum_valid = 1'b0;
            @(negedge clk);
            check({nm, "_nodone"}, bus.done, 0);
            return;
         end
         if (stall) begin
            check({nm, "_hold_v"}, bus.out_valid, 1);
            check({nm, "_hold_d"}, bus.out_data, pd);
            check({nm, "_hold_d16"}, bus16.out_data, pd16);
         end
         if (rmode == 0 && k > 0)
            check({nm, "_b2b"}, bus.out_valid, 1);
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = pat[pi % 7];
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         pi++;
         bus.out_ready  = rdy;
         bus.psum_valid = 1'($urandom_range(0, 1));
         bus.psum_in    = 16'($urandom);
         if (bus.out_valid && rdy) begin
            check({nm, "_d24"}, bus.out_data, exp24[k]);
            check({nm, "_d16"}, bus16.out_data, exp16[k]);
            last24 = bus.out_data;
            last16 = bus16.out_data;
            k++;
         end
         stall = bus.out_valid && !rdy;
         pd    = bus.out_data;
         pd16  = bus16.out_data;
         cyc++;
         @(negedge clk);
      end
      bus.psum_valid = 1'b0;
      bus.out_ready  = 1'b1;
      if (k < eln)
         check({nm, "_timeout"}, k, eln);
      check({nm, "_done"}, bus.done, 1);
      check({nm, "_idle"}, bus.busy, 0);
      check({nm, "_done16"}, bus16.done, 1);
      check({nm, "_ovf"}, bus.ovf, ov24);
      check({nm, "_ovf16"}, bus16.ovf, ov16);
      @(negedge clk);
      check({nm, "_pulse"}, bus.done, 0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n          = 1'b0;
      bus.cfg_start  = 1'b0;
      bus.cfg_npass  = '0;
      bus.cfg_len    = '0;
      bus.cfg_shift  = '0;
      bus.psum_valid = 1'b0;
      bus.psum_in    = '0;
      bus.out_ready  = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_valid", bus.out_valid, 0);
      check("rst_data",  bus.out_data, 0);
      check("rst_busy",  bus.busy, 0);
      check("rst_done",  bus.done, 0);
      check("rst_ovf",   bus.ovf, 0);
      check("rst_busy16", bus16.busy, 0);
      rst_n = 1'b1;
      @(negedge clk);

      ps[0][0] = 5; ps[0][1] = -3; ps[0][2] = 100; ps[0][3] = -128;
      run_tile(1, 4, 0, 0, 0, "t1", -1);

      ps[0][0] = 10; ps[0][1] = -1;
      ps[1][0] = 20; ps[1][1] = -2;
      ps[2][0] = 30; ps[2][1] = -3;
      run_tile(3, 2, 0, 0, 0, "t2", -1);

      ps[0][0] = 6; ps[0][1] = -6; ps[0][2] = 1000;
      run_tile(1, 3, 2, 0, 0, "t3", -1);
      check("t3_sat", last24, 127);

      for (int p = 0; p < 15; p++) ps[p][0] = 32767;
      run_tile(15, 1, 12, 0, 0, "t4", -1);
      check("t4_out24", last24, 120);
      check("t4_out16", last16, 8);
      check("t4_ovf24", bus.ovf, 0);
      check("t4_ovf16", bus16.ovf, 1);

      run_tile(1, 4, 0, 1, 1, "stall", -1);
      run_tile(1, 4, 0, 0, 1, "rst", 2);
      run_tile(0, 0, 5, 2, 1, "full", -1);

      repeat (25)
         run_tile($urandom_range(0, 15), $urandom_range(0, 16),
                  $urandom_range(0, 15), $urandom_range(0, 2),
                  1, "rnd", -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
